// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: final branch/jump resolution stage.
// Resolves condition and target, checks the prediction, redirects fetch.
//
// Ports:
//   clk, reset             clock / synchronous active-high reset
//   br_*                   registered branch operands from the RS/flag buffer
//   negative/zero/
//   overflow/carry         flags of rs1-rs2 (carry=1: rs1>=rs2 unsigned)
//   res_*                  per-instruction resolution pulse
//   redirect_*, flush_*    fetch redirect and flush boundary
//   btb_upd_*              BTB training strobe
//   link_*                 link-register writeback strobe
//   busy                   high while recovering from a redirect
//   branch_count,
//   mispredict_count       saturating performance counters
module branch_resolve_unit #(
    parameter int PHY_W          = 8,
    parameter int CNT_W          = 16,
    parameter int RECOVER_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_branch,
    input  logic             br_jump,
    input  logic             br_jalr,
    input  logic             br_pred_taken,
    input  logic             br_hit,
    input  logic [31:0]      br_pred_target,
    input  logic [PHY_W-1:0] br_phy,
    input  logic [31:0]      br_inst_num,
    input  logic [31:0]      br_pc,
    input  logic [31:0]      br_imm,
    input  logic [31:0]      br_base,
    input  logic [2:0]       br_funct3,
    input  logic             negative,
    input  logic             zero,
    input  logic             overflow,
    input  logic             carry,
    input  logic             br_link,
    output logic             res_valid,
    output logic [31:0]      res_inst_num,
    output logic             res_mispredict,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      flush_inst_num,
    output logic             btb_upd_valid,
    output logic [31:0]      btb_upd_pc,
    output logic [31:0]      btb_upd_target,
    output logic             btb_upd_taken,
    output logic             link_we,
    output logic [PHY_W-1:0] link_phy,
    output logic [31:0]      link_data,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic [31:0]     flush_d;

    logic        in_valid;
    logic        accept;
    logic        cond;
    logic        taken;
    logic [31:0] sum;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        mispredict;
    logic        redirect;
    logic        btb_we;
    logic        lnk_we;

    always_comb begin
        cond = 1'b0;
        case (br_funct3)
            3'b000:  cond = zero;
            3'b001:  cond = ~zero;
            3'b100:  cond = negative ^ overflow;
            3'b101:  cond = ~(negative ^ overflow);
            3'b110:  cond = ~carry;
            3'b111:  cond = carry;
            default: cond = 1'b0;
        endcase
    end

    // In RECOVER only instructions older than the flush point survive.
    assign in_valid = br_branch | br_jump;
    assign accept   = in_valid &
                      ((state_q == IDLE) | (br_inst_num < flush_inst_num));

    assign taken    = br_jump | (br_branch & cond);
    assign sum      = br_jalr ? (br_base + br_imm) : (br_pc + br_imm);
    assign target   = {sum[31:1], sum[0] & ~br_jalr};
    assign pc_plus4 = br_pc + 32'd4;
    assign next_pc  = taken ? target : pc_plus4;

    assign mispredict = (taken != br_pred_taken) |
                        (taken & (~br_hit | (br_pred_target != target)));

    assign redirect = accept & mispredict;
    assign btb_we   = accept & (br_branch | (br_jump & mispredict));
    assign lnk_we   = accept & br_jump & br_link;

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        flush_d = flush_inst_num;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    state_d = RECOVER;
                    rc_d    = RC_W'(RECOVER_CYCLES);
                    flush_d = br_inst_num;
                end
            end
            RECOVER: begin
                if (redirect) begin
                    rc_d    = RC_W'(RECOVER_CYCLES);
                    flush_d = br_inst_num;
                end else if (rc_q == RC_W'(1)) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q - RC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                rc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            rc_q             <= '0;
            flush_inst_num   <= '0;
            res_valid        <= 1'b0;
            res_inst_num     <= '0;
            res_mispredict   <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            btb_upd_valid    <= 1'b0;
            btb_upd_pc       <= '0;
            btb_upd_target   <= '0;
            btb_upd_taken    <= 1'b0;
            link_we          <= 1'b0;
            link_phy         <= '0;
            link_data        <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            state_q        <= state_d;
            rc_q           <= rc_d;
            flush_inst_num <= flush_d;

            res_valid      <= accept;
            res_inst_num   <= accept ? br_inst_num : '0;
            res_mispredict <= redirect;

            redirect_valid <= redirect;
            redirect_pc    <= redirect ? next_pc : '0;

            btb_upd_valid  <= btb_we;
            btb_upd_pc     <= btb_we ? br_pc : '0;
            btb_upd_target <= btb_we ? target : '0;
            btb_upd_taken  <= btb_we & taken;

            link_we   <= lnk_we;
            link_phy  <= lnk_we ? br_phy : '0;
            link_data <= lnk_we ? pc_plus4 : '0;

            if (accept && !(&branch_count))
                branch_count <= branch_count + CNT_W'(1);
            if (redirect && !(&mispredict_count))
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

    assign busy = (state_q == RECOVER);

endmodule
